regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the register file's single write port between the in-order WB stage and the long-latency multiply/divide unit (MDU), which writes GPRs out of order.
- MDU results are buffered in a small FIFO and drained in cycles when WB does not write.
- A per-register pending scoreboard drives the hazard unit's stall decision.
- Sits between WB/MDU and RegFile; drives RegFile's write port.

Parameters:
DEPTH, 4, MDU result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, cycles a FIFO head may wait before Starve_OUT asserts

Ports:
CLOCK  in  1  system clock
RESET  in  1  synchronous, active-low reset
WBValid_IN  in  1  WB stage has a register write this cycle
WBRegister_IN  in  5  WB destination register
WBData_IN  in  32  WB write data
MDValid_IN  in  1  MDU result valid
MDRegister_IN  in  5  MDU destination register
MDData_IN  in  32  MDU result data
MDReady_OUT  out  1  FIFO can accept an MDU result
MDIssue_IN  in  1  long-latency op issued this cycle
MDIssueRegister_IN  in  5  destination register of the issued op
ReadRegister1_IN  in  5  decode source 1
ReadRegister2_IN  in  5  decode source 2
DestRegister_IN  in  5  decode destination
Stall_OUT  out  1  decode must stall on a pending register
Starve_OUT  out  1  request one bubble so the FIFO can drain
WriteEnable_OUT  out  1  RegFile write enable
WriteRegister_OUT  out  5  RegFile write register
WriteData_OUT  out  32  RegFile write data

Behaviour:
- Clock and reset: one clock, CLOCK. RESET is synchronous and active-low; it is sampled only on the rising edge of CLOCK.
- Reset state: FIFO empty, all scoreboard bits 0, starve counter 0, WriteEnable_OUT=0, WriteRegister_OUT=0, WriteData_OUT=0, Starve_OUT=0. Reset mid-operation discards all FIFO contents and pending bits.
- Write to register 0: a write with register 0 is never committed. A WB write to 0 counts as WB idle. An MDU entry to 0 is popped and discarded with no write enable, and no scoreboard bit changes.
- Commit selection, per cycle, with priority:
  - WB wins when WBValid_IN=1 and WBRegister_IN!=0. WB is never stalled or dropped.
  - Otherwise, if the FIFO is not empty, the head is popped.
- Write-port outputs: WriteEnable_OUT, WriteRegister_OUT and WriteData_OUT are registered, so a write appears at RegFile one cycle after selection. When nothing is selected, WriteEnable_OUT=0 and register/data hold their previous values.
- MDU handshake:
  - MDReady_OUT = !full, combinational from FIFO state only.
  - A push occurs when MDValid_IN && MDReady_OUT.
  - Push and pop in the same cycle is allowed whenever not full; the count is unchanged.
  - When empty, a pushed entry is poppable the next cycle at the earliest; there is no FIFO bypass.
- Pointers and occupancy: log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH, plus a (log2(DEPTH)+1)-bit count. full = count==DEPTH; empty = count==0.
- Scoreboard, 32 bits, bit 0 hardwired 0:
  - MDIssue_IN sets bit MDIssueRegister_IN.
  - An MDU entry's pop clears its bit in the cycle it is selected.
  - If set and clear hit the same register in one cycle, set wins.
- Stall_OUT (combinational) = pending[ReadRegister1_IN] | pending[ReadRegister2_IN] | pending[DestRegister_IN]. Index 0 always reads 0. The DestRegister_IN term prevents WAW between WB and the MDU.
- Starve counter:
  - Saturates at STARVE_LIMIT.
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Clears on any pop or when the FIFO is empty.
- Starve_OUT = (counter == STARVE_LIMIT), registered. It holds until the next pop. The hazard unit converts it into a WB bubble.
- No state machine beyond the FIFO, scoreboard and counter. Arbitration is stateless priority.

Decomposition:
- Shared package mips_pkg: REG_W=5, DATA_W=32, NUM_REGS=32, and a typedef for the write-request struct {valid, reg, data}.
- One sub-module, md_result_fifo: a parameterised DEPTH FIFO with push/pop/full/empty/count. The arbiter holds the scoreboard, arbitration and starve counter.

Test Plan:
1. Reset, then WBValid_IN=1, WBRegister_IN=5, WBData_IN=0xDEADBEEF -> next cycle WriteEnable_OUT=1, WriteRegister_OUT=5, WriteData_OUT=0xDEADBEEF. With WBRegister_IN=0 -> WriteEnable_OUT=0.
2. MDIssue_IN on register 9, then ReadRegister1_IN=9 -> Stall_OUT=1. MDU pushes (9, 0x12345678) while WB is idle -> commit one cycle after pop, bit 9 clears, Stall_OUT=0.
3. Push 4 MDU results while WBValid_IN=1 continuously -> MDReady_OUT=0 after the 4th push. Starve_OUT=1 exactly 8 cycles after the first entry waits. WB goes idle one cycle -> one pop, Starve_OUT=0, MDReady_OUT=1.
4. WB and MDU valid in the same cycle with the FIFO non-empty -> WB written first, FIFO head written the next idle cycle. The FIFO drains entries in push order across pointer wrap (push 6, pop 6).
5. Assert RESET=0 for one cycle with 3 entries queued and bits 3, 7, 11 pending -> next cycle FIFO empty, MDReady_OUT=1, Stall_OUT=0 for all reads, WriteEnable_OUT=0.
6. MDIssue_IN on register 4 in the same cycle an MDU entry for register 4 pops -> bit 4 remains set (set wins).

Source files
------------

// File: rtl/mips_pkg.sv
// Shared datapath widths and write-port request types for the register file
// write arbiter and its MDU result FIFO.
package mips_pkg;

  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // One buffered MDU result; validity is implied by FIFO occupancy.
  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } md_entry_t;

  function automatic logic is_reg_zero(input logic [REG_W-1:0] r);
    return r == '0;
  endfunction

endpackage

// File: rtl/md_result_fifo.sv
// Power-of-two FIFO holding MDU results until the register file write port
// is free. Push is ignored when full, pop is ignored when empty.
module md_result_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  md_entry_t                push_data_i,
  input  logic                     pop_i,
  output md_entry_t                pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  md_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale slots are unreachable once pointers clear.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between in-order WB and out-of-order
// MDU results, and tracks registers with outstanding MDU writes.
module regfile_write_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              WBValid_IN,
  input  logic [REG_W-1:0]  WBRegister_IN,
  input  logic [DATA_W-1:0] WBData_IN,
  input  logic              MDValid_IN,
  input  logic [REG_W-1:0]  MDRegister_IN,
  input  logic [DATA_W-1:0] MDData_IN,
  output logic              MDReady_OUT,
  input  logic              MDIssue_IN,
  input  logic [REG_W-1:0]  MDIssueRegister_IN,
  input  logic [REG_W-1:0]  ReadRegister1_IN,
  input  logic [REG_W-1:0]  ReadRegister2_IN,
  input  logic [REG_W-1:0]  DestRegister_IN,
  output logic              Stall_OUT,
  output logic              Starve_OUT,
  output logic              WriteEnable_OUT,
  output logic [REG_W-1:0]  WriteRegister_OUT,
  output logic [DATA_W-1:0] WriteData_OUT
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  md_entry_t               push_entry;
  md_entry_t               head;
  logic                    fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    wb_go, pop, push;
  wr_req_t                 commit;

  logic [NUM_REGS-1:0]     pending_q, pending_d;
  logic [CNT_W-1:0]        starve_cnt_q, starve_cnt_d;
  logic                    starve_q;
  logic                    we_q;
  logic [REG_W-1:0]        wreg_q;
  logic [DATA_W-1:0]       wdata_q;

  // MDU handshake: a result transfers on any cycle where MDValid_IN and
  // MDReady_OUT are both high; MDReady_OUT depends only on FIFO occupancy.
  assign MDReady_OUT = !fifo_full;
  assign push        = MDValid_IN && MDReady_OUT;
  assign push_entry  = '{addr: MDRegister_IN, data: MDData_IN};

  // WB always has priority; a write to r0 is treated as WB being idle.
  assign wb_go = WBValid_IN && !is_reg_zero(WBRegister_IN);
  assign pop   = !wb_go && !fifo_empty;

  md_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (CLOCK),
    .rst_n_i     (RESET),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    commit = '0;
    if (wb_go) begin
      commit = '{valid: 1'b1, addr: WBRegister_IN, data: WBData_IN};
    end else if (pop && !is_reg_zero(head.addr)) begin
      commit = '{valid: 1'b1, addr: head.addr, data: head.data};
    end
  end

  // Issue is applied after retirement so a same-cycle set on a register wins.
  always_comb begin
    pending_d = pending_q;
    if (pop && !is_reg_zero(head.addr)) pending_d[head.addr] = 1'b0;
    if (MDIssue_IN) pending_d[MDIssueRegister_IN] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_MAX) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  assign Stall_OUT = pending_q[ReadRegister1_IN] | pending_q[ReadRegister2_IN]
                   | pending_q[DestRegister_IN];

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      pending_q    <= '0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
      we_q         <= 1'b0;
      wreg_q       <= '0;
      wdata_q      <= '0;
    end else begin
      pending_q    <= pending_d;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= (starve_cnt_d == CNT_MAX);
      we_q         <= commit.valid;
      if (commit.valid) begin
        wreg_q  <= commit.addr;
        wdata_q <= commit.data;
      end
    end
  end

  assign Starve_OUT        = starve_q;
  assign WriteEnable_OUT   = we_q;
  assign WriteRegister_OUT = wreg_q;
  assign WriteData_OUT     = wdata_q;

  occupancy_bound : assert property (@(posedge CLOCK) disable iff (!RESET)
    fifo_count <= ($clog2(DEPTH)+1)'(DEPTH));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed bench for regfile_write_arbiter, checked against a
// queue-and-array reference of the write-port sharing rules.
module tb_regfile_write_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        CLOCK;
  logic        RESET;
  logic        WBValid_IN;
  logic [4:0]  WBRegister_IN;
  logic [31:0] WBData_IN;
  logic        MDValid_IN;
  logic [4:0]  MDRegister_IN;
  logic [31:0] MDData_IN;
  logic        MDReady_OUT;
  logic        MDIssue_IN;
  logic [4:0]  MDIssueRegister_IN;
  logic [4:0]  ReadRegister1_IN;
  logic [4:0]  ReadRegister2_IN;
  logic [4:0]  DestRegister_IN;
  logic        Stall_OUT;
  logic        Starve_OUT;
  logic        WriteEnable_OUT;
  logic [4:0]  WriteRegister_OUT;
  logic [31:0] WriteData_OUT;

  regfile_write_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .CLOCK              (CLOCK),
    .RESET              (RESET),
    .WBValid_IN         (WBValid_IN),
    .WBRegister_IN      (WBRegister_IN),
    .WBData_IN          (WBData_IN),
    .MDValid_IN         (MDValid_IN),
    .MDRegister_IN      (MDRegister_IN),
    .MDData_IN          (MDData_IN),
    .MDReady_OUT        (MDReady_OUT),
    .MDIssue_IN         (MDIssue_IN),
    .MDIssueRegister_IN (MDIssueRegister_IN),
    .ReadRegister1_IN   (ReadRegister1_IN),
    .ReadRegister2_IN   (ReadRegister2_IN),
    .DestRegister_IN    (DestRegister_IN),
    .Stall_OUT          (Stall_OUT),
    .Starve_OUT         (Starve_OUT),
    .WriteEnable_OUT    (WriteEnable_OUT),
    .WriteRegister_OUT  (WriteRegister_OUT),
    .WriteData_OUT      (WriteData_OUT)
  );

  // Clock / reset
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Reference model state: queued MDU results as {reg, data}
  logic [36:0] exp_q[$];
  bit          pend[32];
  int          wait_cnt;
  logic        exp_we;
  logic [4:0]  exp_wr;
  logic [31:0] exp_wd;
  logic        exp_starve;
  bit          model_ok;

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver: applies one cycle of inputs, checks combinational outputs before
  // the edge and registered outputs after it.
  task automatic drive_cycle(input logic rst_n,
                             input logic wb_v, input logic [4:0] wb_r, input logic [31:0] wb_d,
                             input logic md_v, input logic [4:0] md_r, input logic [31:0] md_d,
                             input logic iss, input logic [4:0] iss_r,
                             input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dst);
    bit          wb_go, pop, push, pre_empty;
    logic [36:0] head;
    RESET = rst_n;
    WBValid_IN = wb_v; WBRegister_IN = wb_r; WBData_IN = wb_d;
    MDValid_IN = md_v; MDRegister_IN = md_r; MDData_IN = md_d;
    MDIssue_IN = iss;  MDIssueRegister_IN = iss_r;
    ReadRegister1_IN = r1; ReadRegister2_IN = r2; DestRegister_IN = dst;
    #1;
    if (model_ok) begin
      check("md_ready", {31'b0, MDReady_OUT}, {31'b0, exp_q.size() < DEPTH});
      check("stall", {31'b0, Stall_OUT}, {31'b0, pend[r1] | pend[r2] | pend[dst]});
    end
    pre_empty = (exp_q.size() == 0);
    if (!rst_n) begin
      exp_q.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      wait_cnt = 0; exp_we = 0; exp_wr = 0; exp_wd = 0; exp_starve = 0;
      model_ok = 1'b1;
    end else begin
      wb_go = wb_v && (wb_r != 0);
      pop   = !wb_go && !pre_empty;
      push  = md_v && (exp_q.size() < DEPTH);
      exp_we = 1'b0;
      if (wb_go) begin
        exp_we = 1'b1; exp_wr = wb_r; exp_wd = wb_d;
      end else if (pop) begin
        head = exp_q.pop_front();
        if (head[36:32] != 0) begin
          exp_we = 1'b1; exp_wr = head[36:32]; exp_wd = head[31:0];
          pend[head[36:32]] = 1'b0;
        end
      end
      if (push) exp_q.push_back({md_r, md_d});
      if (iss && iss_r != 0) pend[iss_r] = 1'b1;
      if (pre_empty || pop) wait_cnt = 0;
      else if (wait_cnt < STARVE_LIMIT) wait_cnt++;
      exp_starve = (wait_cnt == STARVE_LIMIT);
    end
    @(posedge CLOCK);
    #1;
    check("write_enable", {31'b0, WriteEnable_OUT}, {31'b0, exp_we});
    check("write_register", {27'b0, WriteRegister_OUT}, {27'b0, exp_wr});
    check("write_data", WriteData_OUT, exp_wd);
    check("starve", {31'b0, Starve_OUT}, {31'b0, exp_starve});
    @(negedge CLOCK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int wb_pct;
    n_checks = 0; n_errors = 0; model_ok = 1'b0;
    RESET = 1'b0; WBValid_IN = 0; WBRegister_IN = 0; WBData_IN = 0;
    MDValid_IN = 0; MDRegister_IN = 0; MDData_IN = 0; MDIssue_IN = 0;
    MDIssueRegister_IN = 0; ReadRegister1_IN = 0; ReadRegister2_IN = 0; DestRegister_IN = 0;
    @(negedge CLOCK);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // WB write to r5, then WB write to r0 (idle)
    drive_cycle(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    check("wb_r5_data", WriteData_OUT, 32'hDEADBEEF);
    drive_cycle(1, 1, 0, 32'h11111111, 0, 0, 0, 0, 0, 0, 0, 0);
    check("wb_r0_no_write", {31'b0, WriteEnable_OUT}, 32'd0);

    // Issue to r9, then stall on read, then MDU result retires it
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 0);
    drive_cycle(1, 0, 0, 0, 1, 9, 32'h12345678, 0, 0, 9, 0, 0);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0);
    check("md_r9_data", WriteData_OUT, 32'h12345678);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0);

    // Fill FIFO under continuous WB, starve, then one idle slot
    for (int i = 0; i < 4; i++)
      drive_cycle(1, 1, 5'(i + 1), $urandom, 1, 5'(i + 10), $urandom, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive_cycle(1, 1, 2, $urandom, 1, 3, 1, 0, 0, 0, 0, 0);
    check("starve_after_limit", {31'b0, Starve_OUT}, 32'd1);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("starve_clears_on_pop", {31'b0, Starve_OUT}, 32'd0);

    // Pointer wrap with WB interleaved, then set-wins on r4
    for (int i = 0; i < 6; i++)
      drive_cycle(1, i[0], 7, $urandom, 1, 5'(i + 1), $urandom, 0, 0, 0, 0, 0);
    idle(6);
    drive_cycle(1, 1, 1, 5, 1, 4, 32'hCAFE0004, 1, 4, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0);

    // Reset with entries queued and bits 3, 7, 11 pending
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive_cycle(1, 1, 8, $urandom, 1, 5'(i + 20), $urandom, 1, 11, 0, 0, 0);
    drive_cycle(0, 1, 8, 0, 1, 3, 0, 0, 0, 3, 7, 11);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 7, 11);

    // Randomised phases with varying WB pressure
    wb_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) wb_pct = $urandom_range(0, 3) * 30 + 10;
      drive_cycle(($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 99) < wb_pct), 5'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 15)),
                  5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
